// File: rtl/punc_control_mc.sv
// punc_control_mc: multi-cycle PUnC LC3 control FSM with a req/ack memory handshake and optional timeout
module punc_control_mc #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int ILLEGAL_HALT = 1,
  parameter int TCW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ir,
  input  logic [2:0]  nzp,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_w_en,
  output logic [1:0]  mem_addr_sel,
  output logic        mdr_ld,
  output logic        ir_ld,
  output logic        rf_w_en,
  output logic        rf_w_addr_sel,
  output logic [1:0]  rf_w_data_sel,
  output logic        rf_r0_addr_sel,
  output logic        rf_r1_addr_sel,
  output logic        cc_ld,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic [1:0]  pc_ld_data_sel,
  output logic [2:0]  alu_sel,
  output logic        halted,
  output logic        err
);
  typedef enum logic [2:0] {INIT, FETCH, DECODE, EXEC, EXEC_I, WB, HALT} state_t;
  localparam logic [3:0] OP_BR = 4'b0000, OP_ADD = 4'b0001, OP_LD = 4'b0010, OP_ST = 4'b0011,
                         OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
                         OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100,
                         OP_LEA = 4'b1110, OP_HLT = 4'b1111;
  state_t state;
  logic [TCW-1:0] cnt;
  logic [3:0] op;
  logic ld_op, st_op, ind_op, mem_op, illegal, timeout, unused_ir;
  assign op = ir[15:12];
  assign ld_op = op == OP_LD || op == OP_LDR;
  assign st_op = op == OP_ST || op == OP_STR;
  assign ind_op = op == OP_LDI || op == OP_STI;
  assign mem_op = ld_op || st_op || ind_op;
  assign illegal = op == 4'b1000 || op == 4'b1101;
  assign timeout = TIMEOUT_CYCLES != 0 && mem_req && !mem_ack && cnt + TCW'(1) == TCW'(TIMEOUT_CYCLES);
  assign unused_ir = ^{ir[8:6], ir[4:0]};
  assign rf_r0_addr_sel = 1'b0;
  assign halted = state == HALT;
  // Moore decode of state/opcode; only ir_ld and mdr_ld follow mem_ack combinationally
  always_comb begin
    mem_req = 1'b0;
    mem_w_en = 1'b0;
    mem_addr_sel = 2'd0;
    mdr_ld = 1'b0;
    ir_ld = 1'b0;
    rf_w_en = 1'b0;
    rf_w_addr_sel = 1'b0;
    rf_w_data_sel = 2'd0;
    rf_r1_addr_sel = 1'b0;
    cc_ld = 1'b0;
    pc_ld = 1'b0;
    pc_clr = 1'b0;
    pc_inc = 1'b0;
    pc_ld_data_sel = 2'd0;
    alu_sel = 3'b000;
    case (state)
      INIT: pc_clr = 1'b1;
      FETCH: begin
        mem_req = 1'b1;
        ir_ld = mem_ack;
      end
      DECODE: pc_inc = 1'b1;
      EXEC: begin
        mem_req = mem_op;
        mem_w_en = st_op;
        mem_addr_sel = (op == OP_LDR || op == OP_STR) ? 2'd3 : mem_op ? 2'd1 : 2'd0;
        mdr_ld = (ld_op || ind_op) && mem_ack;
        rf_r1_addr_sel = st_op;
        rf_w_en = op inside {OP_ADD, OP_AND, OP_NOT, OP_JSR, OP_LEA};
        cc_ld = op inside {OP_ADD, OP_AND, OP_NOT, OP_LEA};
        rf_w_addr_sel = op == OP_JSR;
        rf_w_data_sel = op == OP_JSR ? 2'd2 : op == OP_LEA ? 2'd3 : 2'd0;
        pc_ld = op == OP_JMP || op == OP_JSR || (op == OP_BR && (ir[11:9] & nzp) != 3'b000);
        pc_ld_data_sel = op == OP_JMP ? 2'd2 : op == OP_JSR ? (ir[11] ? 2'd1 : 2'd2) : 2'd0;
        alu_sel = op == OP_NOT ? 3'b110 : op == OP_AND ? (ir[5] ? 3'b101 : 3'b011) :
                  op == OP_ADD ? {2'b00, ir[5]} : 3'b000;
      end
      EXEC_I: begin
        mem_req = 1'b1;
        mem_addr_sel = 2'd2;
        mem_w_en = op == OP_STI;
        rf_r1_addr_sel = op == OP_STI;
        mdr_ld = op == OP_LDI && mem_ack;
      end
      WB: begin
        rf_w_en = 1'b1;
        rf_w_data_sel = 2'd1;
        cc_ld = 1'b1;
      end
      default: ;
    endcase
  end
  // state sequencing, wait-cycle counter and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (mem_req && !mem_ack && !timeout) ? cnt + TCW'(1) : '0;
      if (timeout) begin
        state <= HALT;
        err <= 1'b1;
      end else begin
        case (state)
          INIT: state <= FETCH;
          FETCH: if (mem_ack) state <= DECODE;
          DECODE: state <= EXEC;
          EXEC:
            if (mem_op) begin
              if (mem_ack) state <= st_op ? FETCH : ind_op ? EXEC_I : WB;
            end else if (op == OP_HLT) state <= HALT;
            else if (illegal && ILLEGAL_HALT != 0) begin
              state <= HALT;
              err <= 1'b1;
            end else state <= FETCH;
          EXEC_I: if (mem_ack) state <= op == OP_STI ? FETCH : WB;
          WB: state <= FETCH;
          HALT: state <= HALT;
          default: state <= INIT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_punc_control_mc.sv
// tb_punc_control_mc: randomized instruction-level check of the PUnC control FSM against a per-opcode cycle model
module tb_punc_control_mc;
  typedef struct packed {
    logic       mem_req;
    logic       mem_w_en;
    logic [1:0] mem_addr_sel;
    logic       mdr_ld;
    logic       ir_ld;
    logic       rf_w_en;
    logic       rf_w_addr_sel;
    logic [1:0] rf_w_data_sel;
    logic       rf_r0_addr_sel;
    logic       rf_r1_addr_sel;
    logic       cc_ld;
    logic       pc_ld;
    logic       pc_clr;
    logic       pc_inc;
    logic [1:0] pc_ld_data_sel;
    logic [2:0] alu_sel;
    logic       halted;
    logic       err;
  } ctl_t;
  logic clk = 1'b0, rst_n0 = 1'b0, rst_n1 = 1'b0, mem_ack = 1'b0, sel = 1'b0, m_err = 1'b0;
  logic [15:0] ir = 16'h0;
  logic [2:0] nzp = 3'b000;
  wire [22:0] o0, o1;
  wire [22:0] obs = sel ? o1 : o0;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  punc_control_mc u0 (
    .clk(clk), .rst_n(rst_n0), .ir(ir), .nzp(nzp), .mem_ack(mem_ack),
    .mem_req(o0[22]), .mem_w_en(o0[21]), .mem_addr_sel(o0[20:19]), .mdr_ld(o0[18]), .ir_ld(o0[17]),
    .rf_w_en(o0[16]), .rf_w_addr_sel(o0[15]), .rf_w_data_sel(o0[14:13]), .rf_r0_addr_sel(o0[12]),
    .rf_r1_addr_sel(o0[11]), .cc_ld(o0[10]), .pc_ld(o0[9]), .pc_clr(o0[8]), .pc_inc(o0[7]),
    .pc_ld_data_sel(o0[6:5]), .alu_sel(o0[4:2]), .halted(o0[1]), .err(o0[0])
  );
  punc_control_mc #(.TIMEOUT_CYCLES(4), .ILLEGAL_HALT(0)) u1 (
    .clk(clk), .rst_n(rst_n1), .ir(ir), .nzp(nzp), .mem_ack(mem_ack),
    .mem_req(o1[22]), .mem_w_en(o1[21]), .mem_addr_sel(o1[20:19]), .mdr_ld(o1[18]), .ir_ld(o1[17]),
    .rf_w_en(o1[16]), .rf_w_addr_sel(o1[15]), .rf_w_data_sel(o1[14:13]), .rf_r0_addr_sel(o1[12]),
    .rf_r1_addr_sel(o1[11]), .cc_ld(o1[10]), .pc_ld(o1[9]), .pc_clr(o1[8]), .pc_inc(o1[7]),
    .pc_ld_data_sel(o1[6:5]), .alu_sel(o1[4:2]), .halted(o1[1]), .err(o1[0])
  );

  function automatic logic rb();
    return $urandom_range(1, 0) != 0;
  endfunction

  // expected control word for the single EXEC cycle of a non-memory instruction
  function automatic ctl_t exec_word(input logic [15:0] iv, input logic [2:0] nv);
    ctl_t e;
    e = '0;
    case (iv[15:12])
      4'h0: e.pc_ld = (iv[11:9] & nv) != 3'b000;
      4'h1: begin e.rf_w_en = 1; e.cc_ld = 1; e.alu_sel = iv[5] ? 3'b001 : 3'b000; end
      4'h5: begin e.rf_w_en = 1; e.cc_ld = 1; e.alu_sel = iv[5] ? 3'b101 : 3'b011; end
      4'h9: begin e.rf_w_en = 1; e.cc_ld = 1; e.alu_sel = 3'b110; end
      4'hC: begin e.pc_ld = 1; e.pc_ld_data_sel = 2'd2; end
      4'h4: begin
        e.rf_w_en = 1; e.rf_w_addr_sel = 1; e.rf_w_data_sel = 2'd2;
        e.pc_ld = 1; e.pc_ld_data_sel = iv[11] ? 2'd1 : 2'd2;
      end
      4'hE: begin e.rf_w_en = 1; e.rf_w_data_sel = 2'd3; e.cc_ld = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [15:0] rand_instr(input logic ill);
    logic [15:0] v;
    logic [3:0] op;
    v = 16'($urandom);
    do op = 4'($urandom_range(15, 0)); while (op == 4'hF || (!ill && (op == 4'h8 || op == 4'hD)));
    v[15:12] = op;
    return v;
  endfunction

  task automatic chk(input string tag, input ctl_t e);
    n_chk++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic cyc(input string tag, input logic a, input ctl_t e);
    mem_ack = a;
    e.err = m_err;
    #1;
    chk(tag, e);
    @(posedge clk);
    #1;
  endtask

  // kind 0 = instruction fetch, 1 = data read, 2 = data write
  task automatic access(input string tag, input int kind, input logic [1:0] as, input int waits);
    ctl_t e;
    for (int k = 0; k <= waits; k++) begin
      e = '0;
      e.mem_req = 1;
      e.mem_addr_sel = as;
      e.mem_w_en = kind == 2;
      e.rf_r1_addr_sel = kind == 2;
      e.ir_ld = kind == 0 && k == waits;
      e.mdr_ld = kind == 1 && k == waits;
      cyc(tag, k == waits, e);
    end
  endtask

  task automatic wb();
    ctl_t e;
    e = '0;
    e.rf_w_en = 1;
    e.rf_w_data_sel = 2'd1;
    e.cc_ld = 1;
    cyc("wb", rb(), e);
  endtask

  task automatic do_reset(input logic which);
    ctl_t e;
    sel = which;
    rst_n0 = 0;
    rst_n1 = 0;
    m_err = 0;
    e = '0;
    e.pc_clr = 1;
    cyc("reset", rb(), e);
    if (which) rst_n1 = 1; else rst_n0 = 1;
    cyc("init", rb(), e);
  endtask

  task automatic run_instr(input logic [15:0] iv, input logic [2:0] nv, input int wmin, input int wmax);
    ctl_t e;
    logic [3:0] op;
    int w;
    op = iv[15:12];
    w = int'($urandom_range(wmax, wmin));
    access("fetch", 0, 2'd0, w);
    ir = iv;
    nzp = nv;
    e = '0;
    e.pc_inc = 1;
    cyc("decode", rb(), e);
    w = int'($urandom_range(wmax, wmin));
    case (op)
      4'h2, 4'h6: begin access("ld", 1, op == 4'h6 ? 2'd3 : 2'd1, w); wb(); end
      4'h3, 4'h7: access("st", 2, op == 4'h7 ? 2'd3 : 2'd1, w);
      4'hA: begin access("ldi_ptr", 1, 2'd1, w); access("ldi_data", 1, 2'd2, w); wb(); end
      4'hB: begin access("sti_ptr", 1, 2'd1, w); access("sti_data", 2, 2'd2, w); end
      default: begin
        cyc("exec", rb(), exec_word(iv, nv));
        if (op == 4'hF || ((op == 4'h8 || op == 4'hD) && !sel)) begin
          if (op != 4'hF) m_err = 1;
          for (int k = 0; k < 2; k++) begin
            e = '0;
            e.halted = 1;
            cyc("halt", rb(), e);
          end
        end
      end
    endcase
  endtask

  initial begin
    ctl_t e;
    do_reset(0);
    run_instr(16'h1283, 3'b000, 0, 0);
    run_instr(16'hA405, 3'b001, 3, 3);
    run_instr(16'h0403, 3'b010, 0, 2);
    run_instr(16'h0403, 3'b100, 0, 2);
    run_instr(16'h0003, 3'b111, 0, 2);
    run_instr(16'h2A10, 3'b001, 12, 12);
    for (int i = 0; i < 40; i++) run_instr(rand_instr(0), 3'($urandom_range(7, 0)), 0, 3);
    run_instr(16'h8000, 3'b010, 0, 1);
    do_reset(0);
    run_instr(16'hF025, 3'b001, 0, 1);
    do_reset(1);
    for (int i = 0; i < 25; i++) run_instr(rand_instr(1), 3'($urandom_range(7, 0)), 0, 3);
    run_instr(16'h8000, 3'b111, 0, 1);
    run_instr(16'hD123, 3'b111, 0, 1);
    for (int k = 0; k < 4; k++) begin
      e = '0;
      e.mem_req = 1;
      cyc("timeout_wait", 1'b0, e);
    end
    m_err = 1;
    for (int k = 0; k < 2; k++) begin
      e = '0;
      e.halted = 1;
      cyc("timeout_halt", rb(), e);
    end
    do_reset(0);
    access("fetch", 0, 2'd0, 0);
    ir = 16'hB7FF;
    e = '0;
    e.pc_inc = 1;
    cyc("decode", rb(), e);
    access("sti_ptr", 1, 2'd1, 1);
    for (int k = 0; k < 2; k++) begin
      e = '0;
      e.mem_req = 1;
      e.mem_w_en = 1;
      e.mem_addr_sel = 2'd2;
      e.rf_r1_addr_sel = 1;
      cyc("sti_wait", 1'b0, e);
    end
    #3;
    rst_n0 = 0;
    #1;
    e = '0;
    e.pc_clr = 1;
    chk("async_reset", e);
    @(posedge clk);
    #1;
    rst_n0 = 1;
    cyc("reinit", rb(), e);
    run_instr(16'h5A7F, 3'b100, 0, 2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
